// File: rtl/sistema_digital_n.sv
// Register file plus accumulator sequencer: AC = R0 op1 R1 ... opn R[n_ops]. fin pulses 2+2*n_ops cycles after the start edge.
// No backpressure: xs and wr_en are dropped while busy, and the register file stays frozen for the whole run.
module sistema_digital_n #(
    parameter int N     = 8,
    parameter int NREG  = 4,
    parameter int VALOR = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xs,
    input  logic                    wr_en,
    input  logic [$clog2(NREG)-1:0] wr_addr,
    input  logic [N-1:0]            wr_data,
    input  logic [$clog2(NREG)-1:0] rd_addr,
    output logic [N-1:0]            rd_data,
    input  logic [$clog2(NREG)-1:0] n_ops,
    input  logic [NREG-1:0]         op_mask,
    output logic [N-1:0]            acc,
    output logic                    busy,
    output logic                    fin,
    output logic                    ovf
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, EXEC, DONE} state_t;

    state_t            state, state_nx;
    logic [N-1:0]      regs [NREG];
    logic [N-1:0]      ac, t;
    logic [AW-1:0]     idx, n_lat;
    logic [NREG-1:0]   mask_lat;
    logic              ovf_r;
    logic              start, wr_ok, ld_ac, ld_t, step;
    logic [N:0]        sum;
    logic              sub_op, borrow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        wr_ok    = 1'b0;
        ld_ac    = 1'b0;
        ld_t     = 1'b0;
        step     = 1'b0;
        busy     = 1'b1;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                busy  = 1'b0;
                wr_ok = wr_en;
                if (xs) begin
                    start    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                ld_ac    = 1'b1;
                state_nx = (n_lat == '0) ? DONE : FETCH;
            end
            FETCH: begin
                ld_t     = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                step     = 1'b1;
                state_nx = (idx == n_lat) ? DONE : FETCH;
            end
            DONE: begin
                fin      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A write and a start in the same IDLE cycle both land on this edge,
    // so LOAD on the following edge already sees the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= N'(VALOR);
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];

    assign sum    = {1'b0, ac} + {1'b0, t};
    assign sub_op = mask_lat[idx];
    assign borrow = (ac < t);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac       <= '0;
            t        <= '0;
            idx      <= '0;
            n_lat    <= '0;
            mask_lat <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (start) begin
                n_lat    <= n_ops;
                mask_lat <= op_mask;
                idx      <= AW'(1);
                ovf_r    <= 1'b0;
            end
            if (ld_ac) begin
                ac <= regs[0];
            end
            if (ld_t) begin
                t <= regs[idx];
            end
            if (step) begin
                idx <= idx + AW'(1);
                if (sub_op) begin
                    ac <= ac - t;
                    if (borrow) begin
                        ovf_r <= 1'b1;
                    end
                end else begin
                    ac <= sum[N-1:0];
                    if (sum[N]) begin
                        ovf_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign acc = ac;
    assign ovf = ovf_r;

endmodule
